// File: rtl/c64_mem_pkg.sv
// Purpose: shared region encoding, address map constants and port bit indexes for the C64 memory map.
// Latency: n/a (types, constants and a combinational decode helper only).
// Backpressure: n/a.
`timescale 1ns/1ps
package c64_mem_pkg;

   typedef enum logic [2:0] {
      REG_RAM    = 3'd0,
      REG_BASIC  = 3'd1,
      REG_KERNAL = 3'd2,
      REG_CHAR   = 3'd3,
      REG_IO     = 3'd4,
      REG_PORT   = 3'd5
   } region_t;

   localparam logic [15:0] DDR_ADDR    = 16'h0000;
   localparam logic [15:0] DATA_ADDR   = 16'h0001;
   localparam logic [15:0] BASIC_BASE  = 16'hA000;
   localparam logic [15:0] KERNAL_BASE = 16'hE000;
   localparam logic [15:0] IO_BASE     = 16'hD000;

   // Processor port bit positions.
   localparam int LORAM      = 0;
   localparam int HIRAM      = 1;
   localparam int CHAREN     = 2;
   localparam int CASS_SENSE = 4;

   // External pins that actually reach the port when undriven (bits 3-5).
   localparam logic [7:0] PORT_IN_MASK = 8'h38;

   // No-cartridge map (GAME = EXROM = 1). bank = {charen, hiram, loram}.
   function automatic region_t decode_region(input logic [15:0] addr,
                                             input logic [2:0]  bank);
      logic    l, h, c;
      region_t r;
      l = bank[LORAM];
      h = bank[HIRAM];
      c = bank[CHAREN];
      r = REG_RAM;
      if (addr[15:1] == DDR_ADDR[15:1])
         r = REG_PORT;
      else if (addr[15:13] == BASIC_BASE[15:13])
         r = (l & h) ? REG_BASIC : REG_RAM;
      else if (addr[15:13] == KERNAL_BASE[15:13])
         r = h ? REG_KERNAL : REG_RAM;
      else if (addr[15:12] == IO_BASE[15:12])
         r = (l | h) ? (c ? REG_IO : REG_CHAR) : REG_RAM;
      return r;
   endfunction

endpackage

// File: rtl/c64_port_fade.sv
// Purpose: models the capacitive hold of one floating processor-port bit (6 or 7).
// Latency: value captured each edge while driven; holds FADE_CYCLES cycles after release, then reads 0.
// Backpressure: none.
// Ports: clk/reset (async active-low), ddr_bit/data_bit (registered port bits), fade_val (held level).
`timescale 1ns/1ps
module c64_port_fade #(
   parameter int FADE_CYCLES = 4096,
   parameter int FADE_CW     = 13
) (
   input  logic clk,
   input  logic reset,
   input  logic ddr_bit,
   input  logic data_bit,
   output logic fade_val
);

   localparam logic [FADE_CW-1:0] CNT_INIT = FADE_CW'(FADE_CYCLES);

   logic [FADE_CW-1:0] r_cnt;
   logic               r_fade;

   // While driven, keep tracking the output and reload the hold time, so the
   // edge that releases the pin captures the last driven value.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt  <= '0;
         r_fade <= 1'b0;
      end else if (ddr_bit) begin
         r_fade <= data_bit;
         r_cnt  <= CNT_INIT;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - FADE_CW'(1);
         if (r_cnt == FADE_CW'(1))
            r_fade <= 1'b0;
      end
   end

   assign fade_val = r_fade;

endmodule

// File: rtl/c64_mem_map.sv
// Purpose: 6510 processor port plus C64 no-cartridge bank decode between the CPU and RAM/ROM/IO.
// Latency: reads are combinational (same cycle); port writes and banking changes apply from the next cycle.
// Backpressure: none; every access completes in its own cycle.
// Ports: ab/we/cpu_dout in, cpu_di out; ram/basic/kernal/char/io read data in;
//        ram_we, io_cs, io_we out; port_in pins in; port_out, port_ddr, bank out.
`timescale 1ns/1ps
module c64_mem_map
   import c64_mem_pkg::*;
#(
   parameter int FADE_CYCLES = 4096,
   parameter int FADE_CW     = 13
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] ab,
   input  logic        we,
   input  logic [7:0]  cpu_dout,
   output logic [7:0]  cpu_di,
   input  logic [7:0]  ram_dout,
   output logic        ram_we,
   input  logic [7:0]  basic_dout,
   input  logic [7:0]  kernal_dout,
   input  logic [7:0]  char_dout,
   input  logic [7:0]  io_dout,
   output logic        io_cs,
   output logic        io_we,
   input  logic [7:0]  port_in,
   output logic [7:0]  port_out,
   output logic [7:0]  port_ddr,
   output logic [2:0]  bank
);

   logic [7:0] r_ddr;
   logic [7:0] r_data;
   logic [1:0] w_fade;
   logic [7:0] w_undriven;
   logic [7:0] w_pins;
   region_t    w_region;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ddr  <= 8'h00;
         r_data <= 8'h00;
      end else if (we) begin
         if (ab == DDR_ADDR)
            r_ddr <= cpu_dout;
         if (ab == DATA_ADDR)
            r_data <= cpu_dout;
      end
   end

   c64_port_fade #(.FADE_CYCLES(FADE_CYCLES), .FADE_CW(FADE_CW)) u_fade6 (
      .clk      (clk),
      .reset    (reset),
      .ddr_bit  (r_ddr[6]),
      .data_bit (r_data[6]),
      .fade_val (w_fade[0])
   );

   c64_port_fade #(.FADE_CYCLES(FADE_CYCLES), .FADE_CW(FADE_CW)) u_fade7 (
      .clk      (clk),
      .reset    (reset),
      .ddr_bit  (r_ddr[7]),
      .data_bit (r_data[7]),
      .fade_val (w_fade[1])
   );

   // Levels seen on undriven pins: pull-ups on 0-2, external pins on 3-5,
   // decaying held charge on 6-7.
   assign w_undriven = {w_fade, 6'b00_0000} | (port_in & PORT_IN_MASK) | 8'h07;
   assign w_pins     = (r_ddr & r_data) | (~r_ddr & w_undriven);

   assign port_out = r_data & r_ddr;
   assign port_ddr = r_ddr;
   assign bank     = w_pins[2:0];

   assign w_region = decode_region(ab, bank);
   assign io_cs    = (w_region == REG_IO);
   assign io_we    = we & io_cs;
   // Writes under ROM/CHAR and to the port registers also land in RAM.
   assign ram_we   = we & ~io_cs;

   always_comb begin
      cpu_di = 8'hFF;
      if (!we) begin
         case (w_region)
            REG_BASIC:  cpu_di = basic_dout;
            REG_KERNAL: cpu_di = kernal_dout;
            REG_CHAR:   cpu_di = char_dout;
            REG_IO:     cpu_di = io_dout;
            REG_PORT:   cpu_di = ab[0] ? w_pins : r_ddr;
            default:    cpu_di = ram_dout;
         endcase
      end
   end

endmodule
